// File: rtl/vis_sequencer.sv
// Slice/sample/window sequencer for the correlator chain: walks TRATE slices per
// buffered sample, COUNT samples per window, then idles DRAIN cycles for the merge chain.
module vis_sequencer #(
  parameter  int TRATE = 30,
  parameter  int COUNT = 16,
  parameter  int DRAIN = 8,
  parameter  int WBITS = 16,
  localparam int TBITS = (TRATE > 1) ? $clog2(TRATE) : 1,
  localparam int CBITS = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             buf_ready_i,
  output logic             buf_take_o,
  output logic             sig_valid_o,
  output logic             sig_first_o,
  output logic             sig_next_o,
  output logic             sig_emit_o,
  output logic             sig_last_o,
  output logic [TBITS-1:0] sig_addr_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic [WBITS-1:0] win_count_o
);

  localparam int GBITS = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [TBITS-1:0] SLICE_LAST = TBITS'(TRATE - 1);
  localparam logic [CBITS-1:0] SAMP_LAST  = CBITS'(COUNT - 1);
  localparam logic [GBITS-1:0] GAP_LAST   = GBITS'((DRAIN > 0) ? DRAIN - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [TBITS-1:0] slice_q, slice_d;
  logic [CBITS-1:0] samp_q, samp_d;
  logic [GBITS-1:0] gap_q, gap_d;

  logic             valid_q, first_q, next_q, emit_q, last_q, take_q, busy_q, stall_q;
  logic             valid_d, first_d, next_d, emit_d, last_d, take_d, stall_d;
  logic [TBITS-1:0] addr_q, addr_d;
  logic [WBITS-1:0] win_q;

  always_comb begin
    state_d = state_q;
    slice_d = slice_q;
    samp_d  = samp_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    first_d = 1'b0;
    next_d  = 1'b0;
    emit_d  = 1'b0;
    last_d  = 1'b0;
    take_d  = 1'b0;
    stall_d = 1'b0;
    addr_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_RUN;
          slice_d = '0;
          samp_d  = '0;
        end
      end
      S_RUN: begin
        // Only slice 0 waits on the buffer; the sample is held until it is taken.
        if (slice_q != '0 || buf_ready_i) begin
          valid_d = 1'b1;
          addr_d  = slice_q;
          next_d  = (slice_q == '0);
          first_d = (slice_q == '0) && (samp_q == '0);
          if (slice_q == SLICE_LAST) begin
            last_d  = 1'b1;
            take_d  = 1'b1;
            slice_d = '0;
            if (samp_q == SAMP_LAST) begin
              emit_d = 1'b1;
              samp_d = '0;
              if (DRAIN > 0) begin
                state_d = S_DRAIN;
                gap_d   = '0;
              end else if (!enable_i) begin
                state_d = S_IDLE;
              end
            end else begin
              samp_d = samp_q + 1'b1;
            end
          end else begin
            slice_d = slice_q + 1'b1;
          end
        end else begin
          stall_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (gap_q == GAP_LAST) begin
          state_d = enable_i ? S_RUN : S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      slice_q <= '0;
      samp_q  <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      next_q  <= 1'b0;
      emit_q  <= 1'b0;
      last_q  <= 1'b0;
      take_q  <= 1'b0;
      stall_q <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      slice_q <= slice_d;
      samp_q  <= samp_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      first_q <= first_d;
      next_q  <= next_d;
      emit_q  <= emit_d;
      last_q  <= last_d;
      take_q  <= take_d;
      stall_q <= stall_d;
      busy_q  <= (state_d != S_IDLE);
      addr_q  <= addr_d;
      // Counts the emit one cycle after it is presented.
      if (emit_q) win_q <= win_q + 1'b1;
    end
  end

  assign buf_take_o  = take_q;
  assign sig_valid_o = valid_q;
  assign sig_first_o = first_q;
  assign sig_next_o  = next_q;
  assign sig_emit_o  = emit_q;
  assign sig_last_o  = last_q;
  assign sig_addr_o  = addr_q;
  assign busy_o      = busy_q;
  assign stall_o     = stall_q;
  assign win_count_o = win_q;

endmodule

// File: doc/vis_sequencer.md
# vis_sequencer

Control sequencer for a correlator-chain block. It reads one sample at a time from the `sigbuffer`. For each sample it issues `TRATE` time-multiplexed slices to the chain, with registered `sig_valid/first/next/emit/last/addr` strobes. It groups `COUNT` samples into one accumulation window. After each window it inserts a drain gap so the merged visibility daisy-chain can empty before the next window starts.

## Interface

Parameters:
- `TRATE`, 30: time-multiplexing rate, i.e. slices per sample.
- `TBITS`, `$clog2(TRATE)`: width of the slice address (localparam).
- `COUNT`, 16: samples per accumulation window; must be ≥ 1.
- `CBITS`, `$clog2(COUNT)` (minimum 1): width of the sample counter (localparam).
- `DRAIN`, 8: idle cycles inserted after each window; 0 is legal.
- `WBITS`, 16: width of the window counter.

Ports:
- `clock` in 1: system clock. This block uses one clock only.
- `reset` in 1: synchronous, active-high reset.
- `enable_i` in 1: run request. It is sampled only at window boundaries.
- `buf_ready_i` in 1: `sigbuffer` holds a complete sample, readable through `sig_dati/q`.
- `buf_take_o` out 1: one-cycle pulse that releases the current sample.
- `sig_valid_o` out 1: the slice is valid.
- `sig_first_o` out 1: slice 0 of sample 0 of the window.
- `sig_next_o` out 1: slice 0 of every sample.
- `sig_emit_o` out 1: final slice of the window; tells the accumulators to output.
- `sig_last_o` out 1: final slice (`TRATE-1`) of every sample.
- `sig_addr_o` out `TBITS`: slice index, 0..`TRATE-1`.
- `busy_o` out 1: the sequencer is in the RUN or DRAIN state.
- `stall_o` out 1: pulses on each bubble cycle caused by `buf_ready_i` being low.
- `win_count_o` out `WBITS`: number of windows emitted; wraps modulo 2^`WBITS`.

## Operation

- **State machine:** three states, IDLE, RUN and DRAIN. Internal counters are `slice` (0..`TRATE-1`), `samp` (0..`COUNT-1`) and `gap` (0..`DRAIN-1`).
- **IDLE:**
  - Behaviour: all strobes are 0.
  - Exit: if `enable_i` is high, go to RUN with `slice` = 0 and `samp` = 0.
- **RUN, at `slice` = 0:**
  - If `buf_ready_i` = 0: issue a bubble. `sig_valid_o` = 0, `stall_o` = 1, counters hold.
  - If `buf_ready_i` = 1: issue the slice.
- **RUN, at `slice` > 0:**
  - Slices are issued back to back, one per cycle.
  - `buf_ready_i` is ignored, because the buffer holds the sample until `buf_take_o`.
- **Strobes for an issued slice:**
  - `sig_valid_o` = 1 and `sig_addr_o` = `slice`.
  - `sig_next_o` = 1 when `slice` = 0.
  - `sig_first_o` = 1 when `slice` = 0 and `samp` = 0.
  - `sig_last_o` = 1 and `buf_take_o` = 1 when `slice` = `TRATE-1`.
  - `sig_emit_o` = 1 when `slice` = `TRATE-1` and `samp` = `COUNT-1`.
- **Counter advance:**
  - `slice` wraps from `TRATE-1` to 0, at which point `samp` increments.
  - When the emit slice is issued, `samp` wraps to 0 and `win_count_o` increments.
  - The state then moves to DRAIN, or directly to RUN or IDLE when `DRAIN` = 0.
- **DRAIN:**
  - Strobes are 0; `gap` counts 0..`DRAIN-1`.
  - On exit, go to RUN if `enable_i` is high, otherwise IDLE.
- **`enable_i` low in the middle of a window:** the window completes in full (no truncation), then the sequencer goes to IDLE.
- **`enable_i` high with `buf_ready_i` low in IDLE:** the sequencer still enters RUN and bubbles at slice 0.
- **`COUNT` = 1:** `sig_first_o`, `sig_next_o`, `sig_last_o` and `sig_emit_o` follow the per-sample rules above, so `sig_emit_o` fires on every sample.
- **`TRATE` = 1:** `sig_next_o` and `sig_last_o` assert together on the single slice.

## Timing

- All outputs are registered.
- **Reset:** every output and counter is 0 in the cycle after `reset` is sampled high, including `win_count_o`. The state becomes IDLE. A reset in the middle of a window abandons that window: no emit and no take.
- **Start latency:** `enable_i` high at edge t in IDLE, then RUN at t+1. If `buf_ready_i` is high at t+1, the first valid slice appears at t+2, carrying `first`, `next`, `addr` 0.
- **Within a sample:** one slice per cycle; `sig_addr_o` increments by exactly 1 per valid cycle.
- **`buf_take_o`:** coincides with `sig_last_o`. `sigbuffer` updates `buf_ready_i` no earlier than the following cycle. A `buf_ready_i` sampled high in the cycle immediately after the take belongs to the next sample.
- **Window length:** `COUNT`·`TRATE` valid cycles plus any bubbles. The first valid slice of the next window appears `DRAIN`+1 cycles after the emit cycle.
- **Window counter:** `win_count_o` updates in the cycle after `sig_emit_o`.

## Test plan

All scenarios use `TRATE`=4, `COUNT`=3, `DRAIN`=2 unless stated.

- **Reset mid-window:** assert `reset` at slice 2 of sample 1 → all outputs are 0 on the next cycle and `win_count_o` = 0. Then re-enable → `sig_first_o` appears with `addr` 0.
- **Continuous run:** hold `buf_ready_i` = 1 and enable for 2 windows → `addr` pattern 0,1,2,3 ×3, then 2 idle cycles, then repeat.
  - `first` fires on cycles 0 and 14; `emit` on cycles 11 and 25.
  - 6 `buf_take_o` pulses in total; `win_count_o` = 2.
- **Sample stall:** drop `buf_ready_i` for 3 cycles before sample 1 → exactly 3 `stall_o` bubbles before `addr` 0 of sample 1. There are no gaps inside a sample, and `emit` is delayed by 3 cycles.
- **Disable mid-window:** drop `enable_i` during sample 0 → the window finishes with `emit`, takes 2 drain cycles, then goes IDLE with `busy_o` = 0.
- **Zero drain with `COUNT`=1:** set `COUNT`=1, `DRAIN`=0 → every slice 3 carries `last`+`emit`+`take`, and the next slice 0 carries `first`+`next` on the immediately following cycle.
- **Wrap:** set `WBITS`=2 and run 5 windows → `win_count_o` reads 1,2,3,0,1.
